trace_hasher: RTL and testbench

Front-end stage that turns the raw 32-bit instruction/data trace stream into hash-indexed requests for `neighbour_tracker`. It buffers incoming traces, optionally drops immediate repeats, and computes a 13-bit multiplicative hash of the page ID. It then emits `{index, trace}` with the paired valids that `neighbour_tracker` consumes. It also throttles issue rate so the URAM read/write pipeline downstream is never over-driven.

---
 rtl/trace_hash_pkg.sv | 16 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/trace_hasher.sv | 128 ++++++++++++
 tb/tb_trace_hasher.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_hash_pkg.sv
// Shared widths, default hash constant, emitted-request type and page helper for trace_hasher.
package trace_hash_pkg;
   localparam int          TRACE_W       = 32;
   localparam int          IDX_W         = 13;
   localparam int          PAGE_LSB      = 12;
   localparam logic [31:0] HASH_MULT_DEF = 32'h9E3779B1;

   typedef struct packed {
      logic [IDX_W-1:0]   index;
      logic [TRACE_W-1:0] trace;
   } hashed_trace_t;

   function automatic logic [TRACE_W-PAGE_LSB-1:0] page_of(input logic [TRACE_W-1:0] t);
      return t[TRACE_W-1:PAGE_LSB];
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; head is the oldest entry, read combinationally, no write-to-read bypass.
// Push when full and pop when empty are ignored; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

// File: rtl/trace_hasher.sv
// Buffers traces, hashes page ID to a 13-bit index, optional repeat drop under TRACE_HASHER_DEDUP_EN.
// Latency 3 cycles accept-to-output; in_ready low only when FIFO full; output pulses are never held.
module trace_hasher
   import trace_hash_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter int          ISSUE_GAP  = 0,
   parameter logic [31:0] HASH_MULT  = HASH_MULT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [TRACE_W-1:0] in_trace,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [IDX_W-1:0]   index,
   output logic               index_valid,
   output logic [TRACE_W-1:0] trace,
   output logic               trace_valid,
   output logic [31:0]        emit_count,
   output logic [31:0]        drop_count
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

   logic [CW-1:0]            fifo_count;
   logic [TRACE_W-1:0]       fifo_head;
   logic                     fifo_empty;
   logic                     unused_fifo_full;
   logic                     push;
   logic                     pop;
   logic                     drop;
   logic                     issue;
   logic [GW-1:0]            gap_cnt;
   logic [IDX_W-1:0]         hash_c;
   logic [TRACE_W-IDX_W-1:0] unused_prod_lo;
   logic [IDX_W-1:0]         s1_index;
   logic [TRACE_W-1:0]       s1_trace;
   logic                     s1_vld;
   logic [31:0]              emit_cnt;
   logic [31:0]              drop_cnt;

   assign in_ready = reset && (fifo_count < CW'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = reset && !fifo_empty && (gap_cnt == '0);
   assign issue    = pop && !drop;

   sync_fifo #(.WIDTH(TRACE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (in_trace),
      .pop      (pop),
      .head     (fifo_head),
      .count    (fifo_count),
      .full     (unused_fifo_full),
      .empty    (fifo_empty)
   );

   // Only the top IDX_W bits of the truncated 32-bit product form the index.
   assign {hash_c, unused_prod_lo} = 32'(page_of(fifo_head)) * HASH_MULT;

`ifdef TRACE_HASHER_DEDUP_EN
   logic [TRACE_W-3:0] last_word;
   logic               last_valid;

   assign drop = last_valid && (fifo_head[TRACE_W-1:2] == last_word);

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_word  <= '0;
         last_valid <= 1'b0;
         drop_cnt   <= '0;
      end else if (pop) begin
         if (drop) begin
            if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 1'b1;
         end else begin
            last_word  <= fifo_head[TRACE_W-1:2];
            last_valid <= 1'b1;
         end
      end
   end
`else
   assign drop     = 1'b0;
   assign drop_cnt = '0;
`endif

   // A dropped pop consumes no issue slot, so the gap counter only reloads on issue.
   always_ff @(posedge clk) begin
      if (!reset)              gap_cnt <= '0;
      else if (issue)          gap_cnt <= GW'(ISSUE_GAP);
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_vld   <= 1'b0;
         s1_index <= '0;
         s1_trace <= '0;
         emit_cnt <= '0;
      end else begin
         s1_vld <= issue;
         if (issue) begin
            s1_index <= hash_c;
            s1_trace <= fifo_head;
            if (emit_cnt != 32'hFFFF_FFFF) emit_cnt <= emit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         index       <= '0;
         trace       <= '0;
         index_valid <= 1'b0;
         trace_valid <= 1'b0;
      end else begin
         index_valid <= s1_vld;
         trace_valid <= s1_vld;
         if (s1_vld) begin
            index <= s1_index;
            trace <= s1_trace;
         end
      end
   end

   assign emit_count = emit_cnt;
   assign drop_count = drop_cnt;
endmodule

// File: tb/tb_trace_hasher.sv
// Bench for trace_hasher: three instances (ISSUE_GAP 0/3/15) against a push-order queue model.
`timescale 1ns/1ps
module tb_trace_hasher;
   import trace_hash_pkg::*;

   localparam int N = 3;
`ifdef TRACE_HASHER_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_trace    [N];
   logic        in_valid    [N];
   logic        in_ready    [N];
   logic [12:0] index       [N];
   logic        index_valid [N];
   logic [31:0] trace       [N];
   logic        trace_valid [N];
   logic [31:0] emit_count  [N];
   logic [31:0] drop_count  [N];

   always #5 clk = ~clk;

   trace_hasher #(.FIFO_DEPTH(8), .ISSUE_GAP(0)) u_g0 (
      .clk(clk), .reset(reset), .in_trace(in_trace[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .index(index[0]), .index_valid(index_valid[0]), .trace(trace[0]), .trace_valid(trace_valid[0]),
      .emit_count(emit_count[0]), .drop_count(drop_count[0]));
   trace_hasher #(.FIFO_DEPTH(8), .ISSUE_GAP(3)) u_g3 (
      .clk(clk), .reset(reset), .in_trace(in_trace[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .index(index[1]), .index_valid(index_valid[1]), .trace(trace[1]), .trace_valid(trace_valid[1]),
      .emit_count(emit_count[1]), .drop_count(drop_count[1]));
   trace_hasher #(.FIFO_DEPTH(8), .ISSUE_GAP(15)) u_g15 (
      .clk(clk), .reset(reset), .in_trace(in_trace[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .index(index[2]), .index_valid(index_valid[2]), .trace(trace[2]), .trace_valid(trace_valid[2]),
      .emit_count(emit_count[2]), .drop_count(drop_count[2]));

   // Model state: expected emissions in order, dedup memory, counters.
   hashed_trace_t exp_q     [N][$];
   hashed_trace_t seen_q    [N][$];
   int            pulse_cyc [N][$];
   int            last_pulse[N];
   logic [31:0]   m_last    [N];
   bit            m_last_vld[N];
   logic [31:0]   m_emit    [N];
   logic [31:0]   m_drop    [N];
   int            cyc = 0;
   int            push_cyc;
   int            n_cmp = 0;
   int            n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int gap_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 15);
   endfunction

   function automatic logic [12:0] model_hash(input logic [31:0] t);
      logic [63:0] p;
      p = {32'b0, (t >> 12)} * 64'h0000_0000_9E37_79B1;
      p = p & 64'h0000_0000_FFFF_FFFF;
      return 13'(p >> 19);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] x);
      return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_accept(input int k, input logic [31:0] t);
      hashed_trace_t e;
      if (DEDUP && m_last_vld[k] && ((t >> 2) == (m_last[k] >> 2))) begin
         m_drop[k] = sat_inc(m_drop[k]);
      end else begin
         m_last[k]     = t;
         m_last_vld[k] = 1'b1;
         m_emit[k]     = sat_inc(m_emit[k]);
         e.index       = model_hash(t);
         e.trace       = t;
         exp_q[k].push_back(e);
      end
   endtask

   // Compare process: every negedge, every instance.
   always @(negedge clk) begin
      hashed_trace_t e;
      hashed_trace_t s;
      for (int k = 0; k < N; k++) begin
         check($sformatf("valid_pair[%0d]", k), trace_valid[k], index_valid[k]);
         if (index_valid[k]) begin
            s.index = index[k];
            s.trace = trace[k];
            seen_q[k].push_back(s);
            pulse_cyc[k].push_back(cyc);
            if (last_pulse[k] >= 0) begin
               n_cmp++;
               if (cyc - last_pulse[k] < gap_of(k) + 1) begin
                  n_fail++;
                  $display("FAIL spacing[%0d]: got %0d cycles, required >= %0d", k, cyc - last_pulse[k], gap_of(k) + 1);
               end
            end
            last_pulse[k] = cyc;
            if (exp_q[k].size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_emit[%0d]: got trace %0h, expected none", k, trace[k]);
            end else begin
               e = exp_q[k].pop_front();
               check($sformatf("emit_index[%0d]", k), index[k], e.index);
               check($sformatf("emit_trace[%0d]", k), trace[k], e.trace);
            end
         end
      end
   end

   task automatic push(input int k, input logic [31:0] t, output int waited);
      int w = 0;
      in_trace[k] = t;
      in_valid[k] = 1'b1;
      while (!in_ready[k] && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready[k]) begin
         n_cmp++;
         n_fail++;
         $display("FAIL push_timeout[%0d]: in_ready 0 after %0d cycles, required 1", k, w);
      end else begin
         model_accept(k, t);
      end
      push_cyc = cyc;
      @(negedge clk);
      in_valid[k] = 1'b0;
      waited = w;
   endtask

   task automatic drain();
      int w = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      check("drain_pending", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
      repeat (20) @(negedge clk);
   endtask

   task automatic clear_logs();
      for (int k = 0; k < N; k++) begin
         seen_q[k].delete();
         pulse_cyc[k].delete();
      end
   endtask

   task automatic start_reset();
      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         exp_q[k].delete();
         m_last_vld[k] = 1'b0;
         m_last[k]     = '0;
         m_emit[k]     = '0;
         m_drop[k]     = '0;
         last_pulse[k] = -1;
      end
      clear_logs();
   endtask

   task automatic check_counters(input string tag);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s_emit[%0d]", tag, k), emit_count[k], m_emit[k]);
         check($sformatf("%s_drop[%0d]", tag, k), drop_count[k], m_drop[k]);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s_index[%0d]", tag, k), index[k], 0);
         check($sformatf("%s_trace[%0d]", tag, k), trace[k], 0);
         check($sformatf("%s_ivld[%0d]", tag, k), index_valid[k], 0);
         check($sformatf("%s_tvld[%0d]", tag, k), trace_valid[k], 0);
         check($sformatf("%s_emit[%0d]", tag, k), emit_count[k], 0);
         check($sformatf("%s_drop[%0d]", tag, k), drop_count[k], 0);
         check($sformatf("%s_rdy[%0d]", tag, k), in_ready[k], 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int wsum;
      logic [31:0] t;
      logic [31:0] prev;
      for (int k = 0; k < N; k++) begin
         in_valid[k] = 1'b0;
         in_trace[k] = '0;
      end
      start_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      #1;
      for (int k = 0; k < N; k++) check($sformatf("ready_after_reset[%0d]", k), in_ready[k], 1);

      // Model pins.
      check("model_hash_1004", model_hash(32'h0000_1004), 13'h13C6);
      check("model_hash_0008", model_hash(32'h0000_0008), 13'h0000);

      // Hash values, latency and back-to-back issue.
      clear_logs();
      push(0, 32'h0000_1004, w);
      w = push_cyc;
      push(0, 32'h0000_0008, wsum);
      drain();
      check("hash_pulses", seen_q[0].size(), 2);
      if (seen_q[0].size() == 2) begin
         check("hash_first_index", seen_q[0][0].index, 13'h13C6);
         check("hash_first_trace", seen_q[0][0].trace, 32'h0000_1004);
         check("hash_second_index", seen_q[0][1].index, 13'h0000);
         check("latency", pulse_cyc[0][0] - w, 3);
         check("back_to_back", pulse_cyc[0][1] - pulse_cyc[0][0], 1);
      end

      // Dedup.
      clear_logs();
      push(0, 32'h0000_5010, w);
      push(0, 32'h0000_5011, w);
      push(0, 32'h0000_5014, w);
      drain();
      check("dedup_pulses", seen_q[0].size(), DEDUP ? 2 : 3);
      check("dedup_emit", emit_count[0], DEDUP ? 4 : 5);
      check("dedup_drop", drop_count[0], DEDUP ? 1 : 0);
      check_counters("dedup");

      // Throttle with ISSUE_GAP=3.
      clear_logs();
      wsum = 0;
      for (int i = 0; i < 4; i++) begin
         push(1, 32'h1111_0000 + (i << 12), w);
         wsum += w;
      end
      drain();
      check("throttle_ready_waits", wsum, 0);
      check("throttle_pulses", pulse_cyc[1].size(), 4);
      if (pulse_cyc[1].size() == 4)
         for (int i = 1; i < 4; i++)
            check($sformatf("throttle_gap%0d", i), pulse_cyc[1][i] - pulse_cyc[1][i-1], 4);

      // FIFO full with ISSUE_GAP=15.
      clear_logs();
      wsum = 0;
      for (int i = 0; i < 10; i++) begin
         push(2, 32'h2000_0000 + (i << 4), w);
         if (i < 9) wsum += w;
      end
      check("full_early_waits", wsum, 0);
      check("full_tenth_wait", w, 9);
      drain();
      check("full_pulses", seen_q[2].size(), 10);
      check_counters("full");

      // Mid-run reset with three traces in flight behind a priming emission.
      clear_logs();
      push(2, 32'h3000_0000, w);
      push(2, 32'h3000_1000, w);
      push(2, 32'h3000_2000, w);
      push(2, 32'h3000_3000, w);
      start_reset();
      @(negedge clk);
      check_all_zero("midreset");
      reset = 1'b1;
      #1;
      check("midreset_ready", in_ready[2], 1);
      repeat (30) @(negedge clk);
      #1;
      check("midreset_no_emit", seen_q[2].size(), 0);
      push(2, 32'h3000_0000, w);
      drain();
      check("midreset_repeat_emitted", seen_q[2].size(), 1);
      check("midreset_emit", emit_count[2], 1);
      check_counters("midreset");

      // Randomized traffic, with near-repeats to exercise dedup.
      for (int k = 0; k < N; k++) begin
         prev = $urandom;
         for (int i = 0; i < 25; i++) begin
            t = $urandom;
            if ($urandom_range(0, 2) == 0) t = prev ^ 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) t = prev;
            push(k, t, w);
            prev = t;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      drain();
      check_counters("random");

      // Saturation of emit_count.
      force u_g0.emit_cnt = 32'hFFFF_FFFE;
      @(negedge clk);
      release u_g0.emit_cnt;
      m_emit[0] = 32'hFFFF_FFFE;
      push(0, 32'h4000_0000, w);
      push(0, 32'h4000_1000, w);
      push(0, 32'h4000_2000, w);
      drain();
      check("sat_emit", emit_count[0], 32'hFFFF_FFFF);
      check_counters("sat");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
